// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: FETCH -> EXEC -> FETCH/HALT.
// Optional misaligned-target trap enabled by defining PC_FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter int                    PC_WIDTH    = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic                     imem_ready,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    output logic [INSTR_WIDTH-1:0]   ir,
    output logic                     ir_valid,
    output logic [PC_WIDTH-1:0]      pc,
    output logic [PC_WIDTH-1:0]      pc_plus4,
    input  logic                     exec_done,
    input  logic                     halt_req,
    input  logic [1:0]               PS,
    input  logic [PC_WIDTH-1:0]      br_offset,
    input  logic [3:0]               cond,
    input  logic [PC_WIDTH-1:0]      PC_in,
    input  logic [3:0]               Status,
    output logic                     halted,
    output logic                     fault
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_HALT  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] br_shift;
    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] next_pc;

    // Status is {V,C,N,Z}; odd codes below 1110 invert the even base test.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] s);
        logic v, cf, n, z, r;
        v  = s[3];
        cf = s[2];
        n  = s[1];
        z  = s[0];
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cf;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cf & ~z;
            3'd5:    r = (n == v);
            3'd6:    r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && (c[3:1] != 3'd7))
            r = ~r;
        return r;
    endfunction

    assign br_shift  = br_offset << 2;
    assign br_target = pc + br_shift;
    assign pc_plus4  = pc + PC_WIDTH'(4);
    assign imem_addr = pc;
    // Gated by rst so an in-flight request drops for the whole reset window.
    assign imem_req  = (state == S_FETCH) && !rst;

    always_comb begin
        next_pc = pc_plus4;
        case (PS)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = br_target;
            2'b10:   next_pc = PC_in;
            default: next_pc = cond_eval(cond, Status) ? br_target : pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir       <= imem_rdata;
                        ir_valid <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        ir_valid <= 1'b0;
                        if (halt_req) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            pc <= next_pc;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                            if (next_pc[1:0] != 2'b00) begin
                                fault <= 1'b1;
                                state <= S_FAULT;
                            end else begin
                                state <= S_FETCH;
                            end
`else
                            state <= S_FETCH;
`endif
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; a tiny memory responder returns addr-derived words.
module tb_pc_fetch_unit;

    localparam int PW = 64;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ready;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] ir;
    logic          ir_valid;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_plus4;
    logic          exec_done;
    logic          halt_req;
    logic [1:0]    PS;
    logic [PW-1:0] br_offset;
    logic [3:0]    cond;
    logic [PW-1:0] PC_in;
    logic [3:0]    Status;
    logic          halted;
    logic          fault;

    int errors = 0;
    int checks = 0;

    pc_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid),
        .pc(pc), .pc_plus4(pc_plus4), .exec_done(exec_done), .halt_req(halt_req),
        .PS(PS), .br_offset(br_offset), .cond(cond), .PC_in(PC_in), .Status(Status),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_exec();
        imem_ready = 1'b1;
        exec_done  = 1'b0;
        tick();
    endtask

    task automatic retire(input logic [1:0] ps, input logic [PW-1:0] off,
                          input logic [3:0] c, input logic [3:0] st, input logic [PW-1:0] tgt);
        PS = ps; br_offset = off; cond = c; Status = st; PC_in = tgt;
        halt_req  = 1'b0;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL rst_ir: got %h want 0", ir); end
        checks++; if ({ir_valid, halted, fault} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {ir_valid, halted, fault}); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_release_req: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        logic [PW-1:0] a;
        imem_ready = 1'b1; exec_done = 1'b1; PS = 2'b00; halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 64'(4 * i);
            checks++; if ({imem_req, ir_valid, imem_addr} !== {2'b10, a}) begin
                errors++; $display("FAIL seq_fetch%0d: got req=%b vld=%b addr=%h want req=1 vld=0 addr=%h", i, imem_req, ir_valid, imem_addr, a); end
            tick();
            checks++; if ({imem_req, ir_valid, ir, pc_plus4} !== {2'b01, mem_word(a), a + 64'd4}) begin
                errors++; $display("FAIL seq_exec%0d: got req=%b vld=%b ir=%h p4=%h want req=0 vld=1 ir=%h p4=%h", i, imem_req, ir_valid, ir, pc_plus4, mem_word(a), a + 64'd4); end
            tick();
        end
        exec_done = 1'b0;
    endtask

    task automatic test_relative();
        go_exec();
        retire(2'b10, '0, 4'h0, 4'h0, 64'h100);
        go_exec();
        retire(2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 4'h0, 4'h0, '0);
        checks++; if (imem_addr !== 64'hF8) begin errors++; $display("FAIL rel_back: got %h want 00000000000000f8", imem_addr); end
        go_exec();
        retire(2'b10, '0, 4'h0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        go_exec();
        checks++; if (pc_plus4 !== 64'h0) begin errors++; $display("FAIL wrap_p4: got %h want 0", pc_plus4); end
        retire(2'b00, '0, 4'h0, 4'h0, '0);
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL wrap_seq: got %h want 0", imem_addr); end
    endtask

    task automatic test_conditional();
        logic [3:0] ct [8] = '{4'b0000, 4'b0000, 4'b1010, 4'b1010, 4'b1110, 4'b1000, 4'b1101, 4'b1011};
        logic [3:0] st [8] = '{4'b0001, 4'b0000, 4'b1010, 4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0010};
        logic       tk [8] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1};
        logic [PW-1:0] want;
        for (int i = 0; i < 8; i++) begin
            go_exec();
            retire(2'b10, '0, 4'h0, 4'h0, 64'h1000);
            go_exec();
            retire(2'b11, 64'd3, ct[i], st[i], 64'hDEAD_0000);
            want = tk[i] ? 64'h100C : 64'h1004;
            checks++; if (imem_addr !== want) begin
                errors++; $display("FAIL cond%0d c=%b st=%b: got %h want %h", i, ct[i], st[i], imem_addr, want); end
        end
    endtask

    task automatic test_stall();
        go_exec();
        retire(2'b10, '0, 4'h0, 4'h0, 64'h3000);
        go_exec();
        retire(2'b00, '0, 4'h0, 4'h0, '0);
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exec_done = i[0];
            tick();
            checks++; if ({imem_req, ir_valid, imem_addr, ir} !== {2'b10, 64'h3004, mem_word(64'h3000)}) begin
                errors++; $display("FAIL stall%0d: got req=%b vld=%b addr=%h ir=%h want req=1 vld=0 addr=3004 ir=%h", i, imem_req, ir_valid, imem_addr, ir, mem_word(64'h3000)); end
        end
        exec_done = 1'b0;
        imem_ready = 1'b1;
    endtask

    task automatic test_halt();
        go_exec();
        retire(2'b10, '0, 4'h0, 4'h0, 64'h2000);
        checks++; if (imem_addr !== 64'h2000) begin errors++; $display("FAIL reg_jump: got %h want 2000", imem_addr); end
        go_exec();
        PS = 2'b00; halt_req = 1'b1; exec_done = 1'b1;
        tick();
        halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++; if ({halted, imem_req, pc} !== {2'b10, 64'h2000}) begin
                errors++; $display("FAIL halt%0d: got halted=%b req=%b pc=%h want halted=1 req=0 pc=2000", i, halted, imem_req, pc); end
            tick();
        end
        exec_done = 1'b0;
    endtask

    task automatic test_rst_midfetch();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        go_exec();
        retire(2'b00, '0, 4'h0, 4'h0, '0);
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if ({pc, ir_valid, imem_req, ir, halted} !== {64'h0, 2'b00, 32'h0, 1'b0}) begin
            errors++; $display("FAIL rst_mid: got pc=%h vld=%b req=%b ir=%h halted=%b want pc=0 vld=0 req=0 ir=0 halted=0", pc, ir_valid, imem_req, ir, halted); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got %b want 1", imem_req); end
        imem_ready = 1'b1;
    endtask

    task automatic test_misalign();
        go_exec();
        retire(2'b10, '0, 4'h0, 4'h0, 64'h2002);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            checks++; if ({fault, pc, imem_req} !== {1'b1, 64'h2002, 1'b0}) begin
                errors++; $display("FAIL trap%0d: got fault=%b pc=%h req=%b want fault=1 pc=2002 req=0", i, fault, pc, imem_req); end
            tick();
        end
`else
        checks++; if ({fault, imem_addr, imem_req} !== {1'b0, 64'h2002, 1'b1}) begin
            errors++; $display("FAIL misalign_fetch: got fault=%b addr=%h req=%b want fault=0 addr=2002 req=1", fault, imem_addr, imem_req); end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        go_exec();
        PS = 2'b10; PC_in = 64'h2002; halt_req = 1'b1; exec_done = 1'b1;
        tick();
        exec_done = 1'b0; halt_req = 1'b0;
        checks++; if ({halted, fault, pc} !== {2'b10, 64'h0}) begin
            errors++; $display("FAIL halt_prio: got halted=%b fault=%b pc=%h want halted=1 fault=0 pc=0", halted, fault, pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
        PS = 2'b00; br_offset = '0; cond = 4'h0; PC_in = '0; Status = 4'h0;
        test_reset();
        test_sequential();
        test_relative();
        test_conditional();
        test_stall();
        test_halt();
        test_rst_midfetch();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
